// File: rtl/envelope_follower_if.sv
// Sample stream, control knobs and detector outputs of envelope_follower.
// The block drives the outputs through the slave modport; the master modport is the driving side.
interface envelope_follower_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ENVELOPE_WIDTH = 32
);
    logic                             sample_valid;
    logic signed [DATA_WIDTH-1:0]     audio_in;
    logic [3:0]                       attack_shift;
    logic [3:0]                       release_shift;
    logic [15:0]                      on_threshold;
    logic [15:0]                      off_threshold;
    logic [15:0]                      hold_ms;
    logic                             peak_clear;
    logic [ENVELOPE_WIDTH-1:0]        envelope_out;
    logic                             envelope_valid;
    logic                             gate_out;
    logic                             gate_on_pulse;
    logic [ENVELOPE_WIDTH-1:0]        peak_out;
    logic                             ms_pulse;

    modport master (
        output sample_valid, audio_in, attack_shift, release_shift,
               on_threshold, off_threshold, hold_ms, peak_clear,
        input  envelope_out, envelope_valid, gate_out, gate_on_pulse,
               peak_out, ms_pulse
    );

    modport slave (
        input  sample_valid, audio_in, attack_shift, release_shift,
               on_threshold, off_threshold, hold_ms, peak_clear,
        output envelope_out, envelope_valid, gate_out, gate_on_pulse,
               peak_out, ms_pulse
    );
endinterface

// File: rtl/envelope_follower.sv
// Two-stage attack/release envelope detector with a threshold gate (IDLE/ACTIVE/HOLD) and ms tick.
// Define ENVELOPE_FOLLOWER_PEAK_EN to build the peak-hold register; otherwise peak_out is tied to 0.
module envelope_follower #(
    parameter int DATA_WIDTH     = 32,
    parameter int ENVELOPE_WIDTH = 32,
    parameter int CYCLES_PER_MS  = 100000
) (
    input  logic               clk,
    input  logic               rst,
    envelope_follower_if.slave bus
);
    localparam int ALIGN_SHIFT = ENVELOPE_WIDTH - DATA_WIDTH + 1;
    localparam int MS_WIDTH    = $clog2(CYCLES_PER_MS + 1);
    localparam logic [MS_WIDTH-1:0] MS_LAST = MS_WIDTH'(CYCLES_PER_MS - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} gate_state_e;

    logic                      magValid_q;
    logic [DATA_WIDTH-2:0]     mag_q, mag_d;
    logic [DATA_WIDTH-1:0]     negAudio;
    logic [3:0]                atkShift_q, relShift_q;
    logic [ENVELOPE_WIDTH-1:0] env_q, env_d, target, diff, step;
    logic                      envValid_q;
    logic [MS_WIDTH-1:0]       msCount_q;
    logic                      msPulse_q;
    gate_state_e               state_q;
    logic [15:0]               holdCount_q;
    logic                      gateOut_q, gateOnPulse_q;
    logic [15:0]               envTop;

    // The most negative sample has no positive twin, so it saturates to the largest magnitude.
    assign negAudio = -bus.audio_in;
    always_comb begin
        mag_d = bus.audio_in[DATA_WIDTH-2:0];
        if (bus.audio_in[DATA_WIDTH-1]) begin
            mag_d = (negAudio[DATA_WIDTH-2:0] == '0) ? '1 : negAudio[DATA_WIDTH-2:0];
        end
    end

    assign target = {mag_q, {ALIGN_SHIFT{1'b0}}};

    // Step is at most the distance to target, so the envelope can neither overshoot nor wrap.
    always_comb begin
        env_d = env_q;
        diff  = '0;
        step  = '0;
        if (target > env_q) begin
            diff  = target - env_q;
            step  = diff >> atkShift_q;
            if (step == '0) step = ENVELOPE_WIDTH'(1);
            env_d = env_q + step;
        end else if (target < env_q) begin
            diff  = env_q - target;
            step  = diff >> relShift_q;
            if (step == '0) step = ENVELOPE_WIDTH'(1);
            env_d = env_q - step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            magValid_q <= 1'b0;
            mag_q      <= '0;
            atkShift_q <= '0;
            relShift_q <= '0;
            envValid_q <= 1'b0;
            env_q      <= '0;
        end else begin
            magValid_q <= bus.sample_valid;
            if (bus.sample_valid) begin
                mag_q      <= mag_d;
                atkShift_q <= bus.attack_shift;
                relShift_q <= bus.release_shift;
            end
            envValid_q <= magValid_q;
            if (magValid_q) env_q <= env_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msCount_q <= '0;
            msPulse_q <= 1'b0;
        end else if (msCount_q == MS_LAST) begin
            msCount_q <= '0;
            msPulse_q <= 1'b1;
        end else begin
            msCount_q <= msCount_q + MS_WIDTH'(1);
            msPulse_q <= 1'b0;
        end
    end

    assign envTop = env_q[ENVELOPE_WIDTH-1 -: 16];

    // Re-arming from HOLD takes priority over the countdown and does not re-announce the note.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            holdCount_q   <= '0;
            gateOut_q     <= 1'b0;
            gateOnPulse_q <= 1'b0;
        end else begin
            gateOnPulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (envValid_q && envTop >= bus.on_threshold) begin
                        state_q       <= ACTIVE;
                        gateOut_q     <= 1'b1;
                        gateOnPulse_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (envValid_q && envTop < bus.off_threshold) begin
                        if (bus.hold_ms == 16'd0) begin
                            state_q   <= IDLE;
                            gateOut_q <= 1'b0;
                        end else begin
                            state_q     <= HOLD;
                            holdCount_q <= bus.hold_ms;
                        end
                    end
                end
                HOLD: begin
                    if (envValid_q && envTop >= bus.on_threshold) begin
                        state_q <= ACTIVE;
                    end else if (msPulse_q) begin
                        holdCount_q <= holdCount_q - 16'd1;
                        if (holdCount_q <= 16'd1) begin
                            state_q   <= IDLE;
                            gateOut_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    gateOut_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.envelope_out   = env_q;
    assign bus.envelope_valid = envValid_q;
    assign bus.gate_out       = gateOut_q;
    assign bus.gate_on_pulse  = gateOnPulse_q;
    assign bus.ms_pulse       = msPulse_q;

`ifdef ENVELOPE_FOLLOWER_PEAK_EN
    logic [ENVELOPE_WIDTH-1:0] peak_q;

    // Clear reloads from the envelope currently on the output rather than zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else if (bus.peak_clear) begin
            peak_q <= env_q;
        end else if (envValid_q && env_q > peak_q) begin
            peak_q <= env_q;
        end
    end

    assign bus.peak_out = peak_q;
`else
    logic unusedPeakClear;
    assign unusedPeakClear = bus.peak_clear;
    assign bus.peak_out    = '0;
`endif
endmodule

// File: tb/tb_envelope_follower.sv
// Scoreboard bench for envelope_follower: stimulus queues hand-computed envelopes, a monitor pops them.
// Peak expectations follow ENVELOPE_FOLLOWER_PEAK_EN.
module tb_envelope_follower;
    localparam int DW  = 32;
    localparam int EW  = 32;
    localparam int CPM = 10;

    typedef struct {
        logic [EW-1:0] env;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [DW-1:0] s;
        logic [3:0]    a;
        logic [3:0]    r;
        logic [EW-1:0] e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   onPulses = 0;
    exp_t expQ[$];
    vec_t vecs[17];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    envelope_follower_if #(.DATA_WIDTH(DW), .ENVELOPE_WIDTH(EW)) bus();

    envelope_follower #(
        .DATA_WIDTH(DW),
        .ENVELOPE_WIDTH(EW),
        .CYCLES_PER_MS(CPM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] sample, input logic [3:0] atk,
                                 input logic [3:0] rel, input logic [EW-1:0] expEnv, input bit track);
        exp_t e;
        @(negedge clk);
        bus.sample_valid  = 1'b1;
        bus.audio_in      = sample;
        bus.attack_shift  = atk;
        bus.release_shift = rel;
        if (track) begin
            e.env = expEnv;
            e.cyc = cyc + 2;
            expQ.push_back(e);
        end
    endtask

    task automatic settle(input int n);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
            expQ.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.gate_on_pulse) onPulses++;
        if (bus.envelope_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("envelope", 64'(bus.envelope_out), 64'(e.env));
                checkOutput("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  relCyc, firstMs, pulsesBefore, msSeen;
        bit  seen, earlyLow, done;
        logic [EW-1:0] expPeak;

        vecs = '{
            '{32'h4000_0000, 4'd0,  4'd0,  32'h8000_0000},
            '{32'h8000_0000, 4'd0,  4'd0,  32'hFFFF_FFFE},
            '{32'h0000_0000, 4'd0,  4'd0,  32'h0000_0000},
            '{32'h4000_0000, 4'd4,  4'd0,  32'h0800_0000},
            '{32'h4000_0000, 4'd4,  4'd0,  32'h0F80_0000},
            '{32'h4000_0000, 4'd4,  4'd0,  32'h1688_0000},
            '{32'h0000_0000, 4'd0,  4'd2,  32'h10E6_0000},
            '{32'h0000_0001, 4'd0,  4'd0,  32'h0000_0002},
            '{32'h0000_0002, 4'd15, 4'd0,  32'h0000_0003},
            '{32'h0000_0002, 4'd15, 4'd0,  32'h0000_0004},
            '{32'h0000_0002, 4'd15, 4'd0,  32'h0000_0004},
            '{32'h0000_0000, 4'd0,  4'd15, 32'h0000_0003},
            '{32'hC000_0000, 4'd0,  4'd0,  32'h8000_0000},
            '{32'hFFFF_FFFF, 4'd0,  4'd0,  32'h0000_0002},
            '{32'h1000_0000, 4'd0,  4'd0,  32'h2000_0000},
            '{32'h2000_0000, 4'd0,  4'd0,  32'h4000_0000},
            '{32'h0000_0000, 4'd0,  4'd0,  32'h0000_0000}
        };

        rst               = 1'b1;
        bus.sample_valid  = 1'b0;
        bus.audio_in      = '0;
        bus.attack_shift  = '0;
        bus.release_shift = '0;
        bus.on_threshold  = 16'hFFFF;
        bus.off_threshold = 16'h0000;
        bus.hold_ms       = 16'd3;
        bus.peak_clear    = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_envelope", 64'(bus.envelope_out), 64'd0);
        checkOutput("rst_valid", 64'(bus.envelope_valid), 64'd0);
        checkOutput("rst_gate", 64'(bus.gate_out), 64'd0);
        checkOutput("rst_gate_pulse", 64'(bus.gate_on_pulse), 64'd0);
        checkOutput("rst_ms_pulse", 64'(bus.ms_pulse), 64'd0);
        checkOutput("rst_peak", 64'(bus.peak_out), 64'd0);

        rst     = 1'b0;
        relCyc  = cyc;
        seen    = 1'b0;
        firstMs = 0;
        for (int i = 0; i < 3 * CPM && !seen; i++) begin
            @(negedge clk);
            if (bus.ms_pulse) begin
                seen    = 1'b1;
                firstMs = cyc;
                checkOutput("first_ms_delay", 64'(cyc - relCyc), 64'(CPM));
            end
        end
        if (!seen) checkOutput("first_ms_timeout", 64'd0, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 3 * CPM && !seen; i++) begin
            @(negedge clk);
            if (bus.ms_pulse) begin
                seen = 1'b1;
                checkOutput("ms_period", 64'(cyc - firstMs), 64'(CPM));
            end
        end
        if (!seen) checkOutput("second_ms_timeout", 64'd0, 64'd1);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].s, vecs[i].a, vecs[i].r, vecs[i].e, 1'b1);
            settle(1);
        end
        for (int i = 14; i < 17; i++) begin
            applyStimulus(vecs[i].s, vecs[i].a, vecs[i].r, vecs[i].e, 1'b1);
        end
        settle(1);
        waitDrain();

        // A reset one cycle after the sample must swallow it: the monitor flags any stray valid.
        applyStimulus(32'h4000_0000, 4'd0, 4'd0, '0, 1'b0);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        rst              = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("midrst_envelope", 64'(bus.envelope_out), 64'd0);
        checkOutput("midrst_gate", 64'(bus.gate_out), 64'd0);

        bus.on_threshold  = 16'h4000;
        bus.off_threshold = 16'h2000;
        bus.hold_ms       = 16'd3;
        pulsesBefore      = onPulses;
        applyStimulus(32'h4000_0000, 4'd0, 4'd0, 32'h8000_0000, 1'b1);
        settle(2);
        @(negedge clk);
        checkOutput("gate_open", 64'(bus.gate_out), 64'd1);
        checkOutput("gate_on_pulse", 64'(bus.gate_on_pulse), 64'd1);
        @(negedge clk);
        checkOutput("gate_on_pulse_width", 64'(bus.gate_on_pulse), 64'd0);

        applyStimulus(32'h0, 4'd0, 4'd0, 32'h0, 1'b1);
        settle(2);
        msSeen = 0; earlyLow = 1'b0; done = 1'b0;
        for (int i = 0; i < 6 * CPM && !done; i++) begin
            @(negedge clk);
            if (msSeen == 3) begin
                checkOutput("gate_release", 64'(bus.gate_out), 64'd0);
                done = 1'b1;
            end else begin
                if (!bus.gate_out) earlyLow = 1'b1;
                if (bus.ms_pulse) msSeen++;
            end
        end
        if (!done) checkOutput("hold_timeout", 64'd0, 64'd1);
        checkOutput("gate_held_in_hold", 64'(earlyLow), 64'd0);
        checkOutput("gate_on_pulse_count", 64'(onPulses - pulsesBefore), 64'd1);

        // Re-arm from HOLD with one millisecond left on the counter.
        applyStimulus(32'h4000_0000, 4'd0, 4'd0, 32'h8000_0000, 1'b1);
        settle(4);
        pulsesBefore = onPulses;
        applyStimulus(32'h0, 4'd0, 4'd0, 32'h0, 1'b1);
        settle(2);
        msSeen = 0; earlyLow = 1'b0;
        for (int i = 0; i < 6 * CPM && msSeen < 2; i++) begin
            @(negedge clk);
            if (!bus.gate_out) earlyLow = 1'b1;
            if (bus.ms_pulse) msSeen++;
        end
        checkOutput("retrigger_ms_seen", 64'(msSeen), 64'd2);
        applyStimulus(32'h4000_0000, 4'd0, 4'd0, 32'h8000_0000, 1'b1);
        settle(1);
        for (int i = 0; i < 4 * CPM; i++) begin
            @(negedge clk);
            if (!bus.gate_out) earlyLow = 1'b1;
        end
        checkOutput("retrigger_gate_never_low", 64'(earlyLow), 64'd0);
        checkOutput("retrigger_no_on_pulse", 64'(onPulses - pulsesBefore), 64'd0);

        bus.hold_ms = 16'd0;
        applyStimulus(32'h0, 4'd0, 4'd0, 32'h0, 1'b1);
        settle(3);
        checkOutput("hold_zero_close", 64'(bus.gate_out), 64'd0);

        // Overlapping thresholds: gate may bounce ACTIVE/HOLD but must stay open.
        bus.hold_ms       = 16'd3;
        bus.on_threshold  = 16'h1000;
        bus.off_threshold = 16'h9000;
        pulsesBefore      = onPulses;
        applyStimulus(32'h4000_0000, 4'd0, 4'd0, 32'h8000_0000, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(32'h4000_0000, 4'd0, 4'd0, 32'h8000_0000, 1'b1);
        settle(4);
        checkOutput("overlap_gate_open", 64'(bus.gate_out), 64'd1);
        checkOutput("overlap_on_pulses", 64'(onPulses - pulsesBefore), 64'd1);
        waitDrain();

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h6000_0000, 4'd0, 4'd0, 32'hC000_0000, 1'b1);
        applyStimulus(32'h1000_0000, 4'd0, 4'd0, 32'h2000_0000, 1'b1);
        settle(4);
        waitDrain();
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
        expPeak = 32'hC000_0000;
`else
        expPeak = 32'h0;
`endif
        checkOutput("peak_hold", 64'(bus.peak_out), 64'(expPeak));
        @(negedge clk);
        bus.peak_clear = 1'b1;
        @(negedge clk);
        bus.peak_clear = 1'b0;
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
        expPeak = 32'h2000_0000;
`else
        expPeak = 32'h0;
`endif
        checkOutput("peak_clear", 64'(bus.peak_out), 64'(expPeak));

        repeat (3) @(negedge clk);
        waitDrain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
